// File: rtl/shift_left_logical_core.sv
// Logical left barrel shifter built from log2(N) cascaded 2:1 mux stages.
// The result is available combinationally and as a once-registered copy.
module shift_left_logical_core #(
    parameter  int N = 32,
    localparam int S = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    input  logic [S-1:0] shamt,
    output logic [N-1:0] out,
    output logic [N-1:0] out_q,
    output logic [S-1:0] shamt_q
);

    logic [N-1:0] out_d;
    logic [S-1:0] shamt_d;

    // Stage k moves every bit up by 2**k when shamt[k] is set; the low bits fill with zero.
    for (genvar k = 0; k < S; k++) begin : g_stage
        logic [N-1:0] src_s;
        logic [N-1:0] dst_s;

        if (k == 0) begin : g_first
            assign src_s = in;
        end else begin : g_chain
            assign src_s = g_stage[k-1].dst_s;
        end

        for (genvar i = 0; i < N; i++) begin : g_bit
            if (i >= (2 ** k)) begin : g_move
                assign dst_s[i] = shamt[k] ? src_s[i - (2 ** k)] : src_s[i];
            end else begin : g_fill
                assign dst_s[i] = shamt[k] ? 1'b0 : src_s[i];
            end
        end
    end

    assign out = g_stage[S-1].dst_s;

    // Next-state values for the pipelined copy.
    always_comb begin
        out_d   = out;
        shamt_d = shamt;
    end

    // Pipelined copy of the result and its shift amount, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= {N{1'b0}};
            shamt_q <= {S{1'b0}};
        end else begin
            out_q   <= out_d;
            shamt_q <= shamt_d;
        end
    end

endmodule

// File: tb/tb_shift_left_logical_core.sv
// Directed and random checks of the shifter at N=32, N=8 and N=6 against a
// plain-arithmetic reference model.
module tb_shift_left_logical_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] in32;
    logic [4:0]  sh32;
    logic [31:0] out32, out32_q;
    logic [4:0]  sh32_q;
    logic [7:0]  in8;
    logic [2:0]  sh8;
    logic [7:0]  out8, out8_q;
    logic [2:0]  sh8_q;
    logic [5:0]  in6;
    logic [2:0]  sh6;
    logic [5:0]  out6, out6_q;
    logic [2:0]  sh6_q;

    int n_checks = 0;
    int n_fails  = 0;

    shift_left_logical_core #(.N(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in(in32), .shamt(sh32),
        .out(out32), .out_q(out32_q), .shamt_q(sh32_q)
    );
    shift_left_logical_core #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in(in8), .shamt(sh8),
        .out(out8), .out_q(out8_q), .shamt_q(sh8_q)
    );
    shift_left_logical_core #(.N(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .in(in6), .shamt(sh6),
        .out(out6), .out_q(out6_q), .shamt_q(sh6_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: multiply by 2**s in wide arithmetic, then keep the low n bits.
    function automatic logic [63:0] model_shl(input logic [63:0] a, input int s, input int n);
        logic [127:0] wide;
        logic [127:0] mask;
        if (s >= n) return 64'd0;
        wide = 128'(a) * (128'd1 << s);
        mask = (128'd1 << n) - 128'd1;
        return 64'(wide & mask);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] r_in, p_in;
    logic [4:0]  r_sh, p_sh;

    initial begin
        rst_n = 1'b0;
        in32 = 32'h1234_5678; sh32 = 5'd4;
        in8  = 8'h00;         sh8  = 3'd0;
        in6  = 6'h00;         sh6  = 3'd0;
        #1;
        check("reset out_q", 64'(out32_q), 64'd0);
        check("reset shamt_q", 64'(sh32_q), 64'd0);
        check("out live in reset", 64'(out32), 64'h2345_6780);
        @(posedge clk); #1;
        check("reset holds out_q", 64'(out32_q), 64'd0);

        // Release reset, then capture 1234_5678 << 4
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("reg out_q", 64'(out32_q), 64'h2345_6780);
        check("reg shamt_q", 64'(sh32_q), 64'd4);

        // All-ones sweep
        in32 = 32'hFFFF_FFFF;
        for (int s = 0; s < 32; s++) begin
            sh32 = 5'(s);
            #1;
            check($sformatf("sweep s=%0d", s), 64'(out32), model_shl(64'hFFFF_FFFF, s, 32));
            #9;
        end
        sh32 = 5'd0;  #1; check("sweep s0 const", 64'(out32), 64'hFFFF_FFFF);
        sh32 = 5'd1;  #1; check("sweep s1 const", 64'(out32), 64'hFFFF_FFFE);
        sh32 = 5'd31; #1; check("sweep s31 const", 64'(out32), 64'h8000_0000);

        // Single-bit and zero cases
        in32 = 32'h0000_0001; sh32 = 5'd31; #1; check("lsb to msb", 64'(out32), 64'h8000_0000);
        in32 = 32'h8000_0000; sh32 = 5'd1;  #1; check("msb drop", 64'(out32), 64'd0);
        in32 = 32'h0000_0000; sh32 = 5'd13; #1; check("zero in", 64'(out32), 64'd0);

        // Random combinational pairs
        for (int k = 0; k < 100; k++) begin
            if (n_fails >= 25) break;
            r_in = $urandom; r_sh = 5'($urandom_range(0, 31));
            in32 = r_in; sh32 = r_sh;
            #1;
            check($sformatf("rand %0d", k), 64'(out32), model_shl(64'(r_in), int'(r_sh), 32));
            #($urandom_range(1, 7));
        end

        // Random registered captures
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            p_in = $urandom; p_sh = 5'($urandom_range(0, 31));
            in32 = p_in; sh32 = p_sh;
            @(posedge clk); #1;
            check($sformatf("rand reg out_q %0d", k), 64'(out32_q), model_shl(64'(p_in), int'(p_sh), 32));
            check($sformatf("rand reg shamt_q %0d", k), 64'(sh32_q), 64'(p_sh));
        end

        // Asynchronous reset between edges
        @(negedge clk); in32 = 32'hDEAD_BEEF; sh32 = 5'd1;
        @(posedge clk); #1;
        check("pre-reset out_q", 64'(out32_q), 64'hBD5B_7DDE);
        #2; rst_n = 1'b0; #1;
        check("async rst out_q", 64'(out32_q), 64'd0);
        check("async rst shamt_q", 64'(sh32_q), 64'd0);
        in32 = 32'h0000_00F0; sh32 = 5'd8; #1;
        check("out live mid-reset", 64'(out32), 64'h0000_F000);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset out_q", 64'(out32_q), 64'h0000_F000);
        check("post-reset shamt_q", 64'(sh32_q), 64'd8);

        // N=8 instance
        in8 = 8'hA5; sh8 = 3'd3; #1; check("n8 a5<<3", 64'(out8), 64'h28);
        sh8 = 3'd7; #1; check("n8 a5<<7", 64'(out8), 64'h80);
        sh8 = 3'd0; #1; check("n8 a5<<0", 64'(out8), 64'hA5);
        for (int k = 0; k < 16; k++) begin
            in8 = 8'($urandom); sh8 = 3'($urandom_range(0, 7)); #1;
            check($sformatf("n8 rand %0d", k), 64'(out8), model_shl(64'(in8), int'(sh8), 8));
        end

        // N=6 instance: shift amounts past the width give zero
        in6 = 6'h3F;
        for (int s = 0; s < 8; s++) begin
            sh6 = 3'(s); #1;
            check($sformatf("n6 s=%0d", s), 64'(out6), model_shl(64'h3F, s, 6));
        end
        in6 = 6'h2D; sh6 = 3'd2; #1; check("n6 2d<<2", 64'(out6), 64'h34);
        @(posedge clk); #1;
        check("n6 reg out_q", 64'(out6_q), 64'h34);
        check("n8 reg shamt_q", 64'(sh8_q), 64'(sh8));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/shift_left_logical_core.md
Name: shift_left_logical_core

Overview:
Parameterized N-bit logical left shifter (barrel shifter) for the datapath/ALU shift unit. The shift result is combinational and zero-latency. The same result is also registered once per clock, for consumers that need a pipelined copy.

Parameters:
N, 32, data width in bits; legal range 2..64; power of two preferred.
S, $clog2(N), shift-amount width; derived, not overridden.

Ports:
clk  input  1  system clock; rising-edge active; drives only the registered copy.
rst_n  input  1  asynchronous, active-low reset; clears the registered outputs.
in  input  N  operand to shift.
shamt  input  S  shift amount, unsigned, 0..2^S-1.
out  output  N  combinational result, in << shamt.
out_q  output  N  registered copy of out.
shamt_q  output  S  registered copy of shamt, for downstream alignment.

Interface rule: one clock (clk); reset is asynchronous and active-low (rst_n).

Behaviour:
- Combinational result:
  - out[i] = in[i-shamt] when i >= shamt; otherwise out[i] = 0.
  - Zero fill from the LSB end. Bits shifted past the MSB are discarded.
  - No sign or rotate behaviour.
- Zero-latency path:
  - out depends only on in and shamt.
  - No clock or reset gating on this path.
  - out must be valid within the combinational propagation delay, well under 1 ns in simulation. There are no delta-cycle races.
- Structure:
  - S cascaded 2:1 mux stages.
  - Stage k shifts by 2^k when shamt[k] = 1, and passes through otherwise.
  - Each stage is generated per bit. No behavioural "<<" on the variable amount.
- Boundary cases:
  - shamt = 0: out = in.
  - shamt = N-1: out = {in[0], (N-1) zeros}.
  - N not a power of two and shamt >= N: out = 0.
  - in all-zero: out = 0 for any shamt.
- Unknown inputs: X/Z on in or shamt may propagate to out. With known inputs, out must never be X or Z.
- Registered copy:
  - On each rising clk edge: out_q <= out and shamt_q <= shamt.
  - No enable; the copy updates every cycle.
- Reset:
  - While rst_n = 0: out_q = 0 and shamt_q = 0, immediately and asynchronously.
  - The combinational out remains live during reset.
  - Release is synchronous to the next rising clk edge after rst_n rises.
- Reset mid-operation: asserting rst_n clears out_q and shamt_q at once, regardless of the clock. The value captured on the last edge is lost.

Test Plan:
- Sweep, N=32, in=32'hFFFF_FFFF, shamt 0..31 stepped every 10 ns -> out = 32'hFFFF_FFFF << shamt; shamt=0 gives FFFF_FFFF, shamt=1 gives FFFF_FFFE, shamt=31 gives 8000_0000.
- Single bit, in=32'h0000_0001, shamt=31 -> out=32'h8000_0000; in=32'h8000_0000, shamt=1 -> out=0.
- Random: 100 random in/shamt pairs, checked 1 ns after each change against the golden in << shamt -> zero mismatches; bench aborts after 25 errors.
- Registered path: rst_n=0 -> out_q=0 and shamt_q=0 immediately. Release rst_n, apply in=32'h1234_5678, shamt=4 -> after the next rising clk, out_q=32'h2345_6780 and shamt_q=4.
- Async reset mid-stream: assert rst_n between clock edges while out_q is nonzero -> out_q=0 before the next edge; out still tracks in << shamt.
- Parameter: N=8, in=8'hA5, shamt=3 -> out=8'h28; N=8, shamt=7 -> out={in[0],7'b0}=8'h80.
